// File: rtl/dsky_relay_decoder.sv
// dsky_relay_decoder
//
// Turns the relay word {RYWD16,RYWD14,RYWD13,RYWD12, RLYB11..RLYB01} into one of
// twelve row registers. The row address is ADDR and the data is DATA[10:0].
// A registered read port returns a row together with its decoded digit pair.
//
// The word passes through a two-flop synchronizer first. The synchronized word W
// is tracked by a small FSM with the states idle, settle and latched. A word whose
// address is nonzero is written once it has been stable long enough. Addresses
// 13..15 write nothing and pulse BADADR instead.
//
// Configuration macro: DSKY_RELAY_SETTLE_EN
//   defined   - W must hold for SETTLE_CYCLES cycles before it is latched.
//   undefined - there is no settle state and no counter. A new nonzero word
//               latches on its first synchronized cycle. SETTLE_CYCLES is ignored.
//
// Ports
//   SIM_CLK              clock
//   SIM_RST              asynchronous reset, active low
//   RYWD12/13/14/16      relay row address bits, weights 1, 2, 4 and 8
//   RLYB01..RLYB11       relay data bits
//   RD_ROW   [3:0]       read row select
//   RD_RAW   [10:0]      stored data of the selected row, one cycle later
//   RD_LEFT  [3:0]       decoded digit of RD_RAW[9:5]
//   RD_RIGHT [3:0]       decoded digit of RD_RAW[4:0]
//   RD_FLAG              RD_RAW[10]
//   UPD                  one-cycle pulse when a row register is written
//   UPD_ROW  [3:0]       row written last
//   BADADR               one-cycle pulse when a settled word has address 13..15
module dsky_relay_decoder #(
    parameter int unsigned SETTLE_CYCLES = 1024  // legal range 1..65535
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        RYWD12,
    input  logic        RYWD13,
    input  logic        RYWD14,
    input  logic        RYWD16,
    input  logic        RLYB01,
    input  logic        RLYB02,
    input  logic        RLYB03,
    input  logic        RLYB04,
    input  logic        RLYB05,
    input  logic        RLYB06,
    input  logic        RLYB07,
    input  logic        RLYB08,
    input  logic        RLYB09,
    input  logic        RLYB10,
    input  logic        RLYB11,
    input  logic [3:0]  RD_ROW,
    output logic [10:0] RD_RAW,
    output logic [3:0]  RD_LEFT,
    output logic [3:0]  RD_RIGHT,
    output logic        RD_FLAG,
    output logic        UPD,
    output logic [3:0]  UPD_ROW,
    output logic        BADADR
);

`ifdef DSKY_RELAY_SETTLE_EN
    typedef enum logic [1:0] {StIdle, StSettle, StLatched} state_e;
    localparam logic [15:0] CntLast = 16'(SETTLE_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {StIdle, StLatched} state_e;
    logic unused_settle_cycles;
    assign unused_settle_cycles = ^SETTLE_CYCLES;
`endif

    function automatic logic [3:0] decode_digit(input logic [4:0] code);
        logic [3:0] d;
        unique case (code)
            5'b00000: d = 4'hA;  // blank
            5'b10101: d = 4'h0;
            5'b00011: d = 4'h1;
            5'b11001: d = 4'h2;
            5'b11011: d = 4'h3;
            5'b01111: d = 4'h4;
            5'b11110: d = 4'h5;
            5'b11100: d = 4'h6;
            5'b10011: d = 4'h7;
            5'b11101: d = 4'h8;
            5'b11111: d = 4'h9;
            default:  d = 4'hF;
        endcase
        return d;
    endfunction

    logic [14:0] word_in, sync1_q, sync2_q, w, cap_q, cap_d;
    logic [3:0]  w_addr;
    state_e      state_q, state_d;
    logic        done, wr_en, bad_d;
    logic        upd_q, badadr_q;
    logic [3:0]  upd_row_q;
    logic [10:0] rd_raw_q, rd_mux;
    logic [10:0] row_q [1:12];

    assign word_in = {RYWD16, RYWD14, RYWD13, RYWD12,
                      RLYB11, RLYB10, RLYB09, RLYB08, RLYB07, RLYB06,
                      RLYB05, RLYB04, RLYB03, RLYB02, RLYB01};
    assign w      = sync2_q;
    assign w_addr = w[14:11];

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= word_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        done    = 1'b0;
`ifdef DSKY_RELAY_SETTLE_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (w_addr != 4'd0) begin
                    cap_d = w;
`ifdef DSKY_RELAY_SETTLE_EN
                    cnt_d   = '0;
                    state_d = StSettle;
`else
                    state_d = StLatched;
                    done    = 1'b1;
`endif
                end
            end
`ifdef DSKY_RELAY_SETTLE_EN
            StSettle: begin
                if (w != cap_q) begin
                    if (w_addr == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        cap_d = w;
                        cnt_d = '0;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StLatched;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            StLatched: begin
                // Holding the latched word does nothing; only a change re-arms.
                if (w != cap_q) begin
                    if (w_addr == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        cap_d = w;
`ifdef DSKY_RELAY_SETTLE_EN
                        cnt_d   = '0;
                        state_d = StSettle;
`else
                        done = 1'b1;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // On completion W equals the captured word, so W carries the address and data.
    assign wr_en = done && (w_addr <= 4'd12);
    assign bad_d = done && (w_addr >= 4'd13);

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q <= StIdle;
            cap_q   <= '0;
`ifdef DSKY_RELAY_SETTLE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
`ifdef DSKY_RELAY_SETTLE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            for (int i = 1; i <= 12; i++) row_q[i] <= '0;
        end else begin
            for (int i = 1; i <= 12; i++) begin
                if (wr_en && (w_addr == 4'(i))) row_q[i] <= w[10:0];
            end
        end
    end

    // Read mux with write-first bypass. Rows 0 and 13..15 read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 1; i <= 12; i++) begin
            if (RD_ROW == 4'(i)) rd_mux = row_q[i];
        end
        if (wr_en && (w_addr == RD_ROW)) rd_mux = w[10:0];
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            upd_q     <= 1'b0;
            badadr_q  <= 1'b0;
            upd_row_q <= '0;
            rd_raw_q  <= '0;
        end else begin
            upd_q    <= wr_en;
            badadr_q <= bad_d;
            rd_raw_q <= rd_mux;
            if (wr_en) upd_row_q <= w_addr;
        end
    end

    assign UPD      = upd_q;
    assign BADADR   = badadr_q;
    assign UPD_ROW  = upd_row_q;
    assign RD_RAW   = rd_raw_q;
    assign RD_FLAG  = rd_raw_q[10];
    assign RD_LEFT  = decode_digit(rd_raw_q[9:5]);
    assign RD_RIGHT = decode_digit(rd_raw_q[4:0]);

endmodule

// File: tb/tb_dsky_relay_decoder.sv
// tb_dsky_relay_decoder
//
// Drives dsky_relay_decoder (SETTLE_CYCLES = 4) with directed relay sequences and
// random held words. Every output is compared against a reference model.
//
// The model keeps twelve plain row values. It notes how long the synchronized word
// has stayed unchanged. A run of one nonzero-address word is acted on exactly once,
// when the run reaches the required length: the settle count plus one cycles, or
// a single cycle when the settle filter is compiled out.
module tb_dsky_relay_decoder;

    localparam int unsigned SETTLE = 4;
`ifdef DSKY_RELAY_SETTLE_EN
    localparam int RUN_NEEDED = SETTLE + 1;
`else
    localparam int RUN_NEEDED = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] word = '0;
    logic [3:0]  rd_row = '0;
    logic [10:0] rd_raw;
    logic [3:0]  rd_left, rd_right, upd_row;
    logic        rd_flag, upd, badadr;

    dsky_relay_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .SIM_CLK (clk),
        .SIM_RST (rst_n),
        .RYWD12  (word[11]),
        .RYWD13  (word[12]),
        .RYWD14  (word[13]),
        .RYWD16  (word[14]),
        .RLYB01  (word[0]),
        .RLYB02  (word[1]),
        .RLYB03  (word[2]),
        .RLYB04  (word[3]),
        .RLYB05  (word[4]),
        .RLYB06  (word[5]),
        .RLYB07  (word[6]),
        .RLYB08  (word[7]),
        .RLYB09  (word[8]),
        .RLYB10  (word[9]),
        .RLYB11  (word[10]),
        .RD_ROW  (rd_row),
        .RD_RAW  (rd_raw),
        .RD_LEFT (rd_left),
        .RD_RIGHT(rd_right),
        .RD_FLAG (rd_flag),
        .UPD     (upd),
        .UPD_ROW (upd_row),
        .BADADR  (badadr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int upd_seen = 0;
    int bad_seen = 0;

    // Reference model state
    logic [14:0] m_s1, m_s2, m_prev;
    int          m_run;
    logic [10:0] m_row [16];
    logic        exp_upd, exp_bad;
    logic [3:0]  exp_upd_row;
    logic [10:0] exp_raw;

    function automatic logic [3:0] ref_digit(input logic [4:0] c);
        case (c)
            5'b00000: return 4'hA;
            5'b10101: return 4'h0;
            5'b00011: return 4'h1;
            5'b11001: return 4'h2;
            5'b11011: return 4'h3;
            5'b01111: return 4'h4;
            5'b11110: return 4'h5;
            5'b11100: return 4'h6;
            5'b10011: return 4'h7;
            5'b11101: return 4'h8;
            5'b11111: return 4'h9;
            default:  return 4'hF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("upd",      32'(upd),      32'(exp_upd));
        check_eq("badadr",   32'(badadr),   32'(exp_bad));
        check_eq("upd_row",  32'(upd_row),  32'(exp_upd_row));
        check_eq("rd_raw",   32'(rd_raw),   32'(exp_raw));
        check_eq("rd_flag",  32'(rd_flag),  32'(exp_raw[10]));
        check_eq("rd_left",  32'(rd_left),  32'(ref_digit(exp_raw[9:5])));
        check_eq("rd_right", 32'(rd_right), 32'(ref_digit(exp_raw[4:0])));
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_prev = '0;
        m_run = 0;
        for (int i = 0; i < 16; i++) m_row[i] = '0;
        exp_upd = 1'b0;
        exp_bad = 1'b0;
        exp_upd_row = '0;
        exp_raw = '0;
    endtask

    // One clock cycle: check what is visible now, drive new inputs, then advance
    // the model across the coming rising edge.
    task automatic cycle(input logic [14:0] w_in, input logic [3:0] row_in);
        logic [14:0] w;
        logic        fire;
        @(negedge clk);
        check_outputs();
        if (upd) upd_seen++;
        if (badadr) bad_seen++;
        word = w_in;
        rd_row = row_in;
        w = m_s2;
        if (w == m_prev) m_run++;
        else m_run = 1;
        m_prev = w;
        fire = (w[14:11] != 4'd0) && (m_run == RUN_NEEDED);
        exp_upd = fire && (w[14:11] <= 4'd12);
        exp_bad = fire && (w[14:11] >= 4'd13);
        if (exp_upd) begin
            m_row[w[14:11]] = w[10:0];
            exp_upd_row = w[14:11];
        end
        exp_raw = (row_in >= 4'd1 && row_in <= 4'd12) ? m_row[row_in] : 11'd0;
        m_s2 = m_s1;
        m_s1 = w_in;
    endtask

    task automatic hold(input logic [14:0] w_in, input logic [3:0] row_in, input int n);
        for (int i = 0; i < n; i++) cycle(w_in, row_in);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        word = '0;
        rd_row = '0;
        #1;
        model_reset();
        check_outputs();  // outputs must clear without waiting for a clock
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int u0, b0;
        logic [14:0] w;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Row 3, flag set, digits 0 and 1
        u0 = upd_seen;
        hold({4'd3, 11'b1_10101_00011}, 4'd3, 12);
        check_eq("r030_upd_count", 32'(upd_seen - u0), 32'd1);
        check_eq("r030_upd_row", 32'(upd_row), 32'd3);
        check_eq("r030_left", 32'(rd_left), 32'h0);
        check_eq("r030_right", 32'(rd_right), 32'h1);
        check_eq("r030_flag", 32'(rd_flag), 32'd1);

        // A data change after 3 cycles restarts settling
        u0 = upd_seen;
        hold({4'd5, 11'h123}, 4'd5, 3);
        hold({4'd5, 11'h456}, 4'd5, 12);
`ifdef DSKY_RELAY_SETTLE_EN
        check_eq("r031_upd_count", 32'(upd_seen - u0), 32'd1);
`else
        check_eq("r031_upd_count", 32'(upd_seen - u0), 32'd2);
`endif
        check_eq("r031_raw", 32'(rd_raw), 32'h456);

        // Bad address: one BADADR pulse and no write
        u0 = upd_seen;
        b0 = bad_seen;
        hold({4'd14, 11'h7FF}, 4'd3, 12);
        check_eq("r032_bad_count", 32'(bad_seen - b0), 32'd1);
        check_eq("r032_upd_count", 32'(upd_seen - u0), 32'd0);
        for (int r = 1; r <= 12; r++) hold('0, 4'(r), 1);

        // Same word re-sent after a zero gap writes again; holding it does not
        u0 = upd_seen;
        hold({4'd7, 11'h2AA}, 4'd7, 10);
        hold('0, 4'd7, 4);
        hold({4'd7, 11'h2AA}, 4'd7, 20);
        check_eq("r033_upd_count", 32'(upd_seen - u0), 32'd2);

        // Reset during settling discards the pending word
        apply_reset();
        u0 = upd_seen;
`ifdef DSKY_RELAY_SETTLE_EN
        hold({4'd2, 11'h3FF}, 4'd2, 4);
`else
        hold({4'd2, 11'h3FF}, 4'd2, 1);
`endif
        apply_reset();
        hold('0, 4'd2, 10);
        check_eq("r034_upd_count", 32'(upd_seen - u0), 32'd0);
        check_eq("r034_raw", 32'(rd_raw), 32'd0);
        check_eq("r034_left", 32'(rd_left), 32'hA);

        // Illegal digit code
        hold({4'd9, 11'b0_11111_01010}, 4'd9, 12);
        check_eq("r035_right", 32'(rd_right), 32'hF);
        check_eq("r035_left", 32'(rd_left), 32'h9);

        // Random held words with random read rows
        for (int s = 0; s < 300; s++) begin
            int len;
            w[14:11] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            w[10:0] = 11'($urandom);
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) cycle(w, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) apply_reset();
        end
        hold('0, 4'd0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
